// File: rtl/serial_sub_pkg.sv
// Shared state encoding for the bit-serial subtractor controller.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_sub_ctrl_full_sub_bit.sv
// 1-bit full subtractor built from two half-subtract gates and an OR for the borrow.
module half_sub_gate (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bo
);
    assign d  = a ^ b;
    assign bo = ~a & b;
endmodule

module full_sub_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);
    logic d1, bo1, bo2;

    half_sub_gate u_h1 (.a(a),  .b(b),   .d(d1), .bo(bo1));
    half_sub_gate u_h2 (.a(d1), .b(bin), .d(d),  .bo(bo2));

    assign bo = bo1 | bo2;
endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b, LSB first, one bit per clock through a shared full_sub_bit cell.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_t            state, nstate;
    logic [WIDTH-1:0]  sa, sb;
    logic [CW-1:0]     cnt;
    logic              bin, d, bo, last;
    logic [WIDTH-1:0]  dmsb;

    full_sub_bit u_fs (.a(sa[0]), .b(sb[0]), .bin(bin), .d(d), .bo(bo));

    assign last = (cnt == CW'(WIDTH - 1));
    // Places the new result bit at the top; written as a shift so WIDTH=1 needs no special case.
    assign dmsb = WIDTH'(d) << (WIDTH - 1);

`ifdef SERIAL_SUB_OVF_EN
    logic am, bm;
`endif

    always_comb begin
        nstate = state;
        busy   = 1'b0;
        done   = 1'b0;
        case (state)
            IDLE: if (start) nstate = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) nstate = DONE;
            end
            DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sa         <= '0;
            sb         <= '0;
            cnt        <= '0;
            bin        <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            am         <= 1'b0;
            bm         <= 1'b0;
            ovf        <= 1'b0;
`endif
        end else begin
            state <= nstate;
            case (state)
                IDLE: if (start) begin
                    sa  <= a;
                    sb  <= b;
                    bin <= 1'b0;
                    cnt <= '0;
`ifdef SERIAL_SUB_OVF_EN
                    am  <= a[WIDTH-1];
                    bm  <= b[WIDTH-1];
`endif
                end
                RUN: begin
                    sa   <= sa >> 1;
                    sb   <= sb >> 1;
                    diff <= (diff >> 1) | dmsb;
                    bin  <= bo;
                    cnt  <= cnt + CW'(1);
                    // Final borrow/overflow land with the last bit so they are valid during done.
                    if (last) begin
                        borrow_out <= bo;
`ifdef SERIAL_SUB_OVF_EN
                        ovf        <= (am ^ bm) & (am ^ d);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl: WIDTH=8 main instance plus a WIDTH=1 instance.
module tb_serial_sub_ctrl;

    typedef struct {
        int         cyc;
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, start1 = 1'b0;
    logic [7:0] a = '0, b = '0, diff;
    logic [0:0] a1 = '0, b1 = '0, diff1;
    logic       busy, done, borrow_out, busy1, done1, borrow1;
    logic       ovf, ovf1;
    int         cyc = 0;
    int         nchk = 0, nerr = 0;
    exp_t       q[$], q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_sub_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf)
`endif
    );

    serial_sub_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow_out(borrow1)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf1)
`endif
    );

`ifndef SERIAL_SUB_OVF_EN
    assign ovf  = 1'b0;
    assign ovf1 = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: pop an expectation whenever a done pulse appears.
    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("diff", {24'h0, diff}, {24'h0, e.d});
                chk("borrow_out", {31'h0, borrow_out}, {31'h0, e.bo});
`ifdef SERIAL_SUB_OVF_EN
                chk("ovf", {31'h0, ovf}, {31'h0, e.ov});
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (done1) begin
            if (q1.size() == 0) chk("unexpected_done_w1", 1, 0);
            else begin
                exp_t e;
                e = q1.pop_front();
                chk("done_cycle_w1", cyc, e.cyc);
                chk("diff_w1", {31'h0, diff1}, {31'h0, e.d[0]});
                chk("borrow_w1", {31'h0, borrow1}, {31'h0, e.bo});
            end
        end
    end

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic [7:0] ed, input logic eb, input logic eo);
        exp_t e;
        int   n;
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        e.cyc = cyc + 9; e.d = ed; e.bo = eb; e.ov = eo;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = ~ta; b = ~tb_v;  // operands must already be captured
        n = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", n, 9);
    endtask

    task automatic run1(input logic ta, input logic tb_v, input logic ed, input logic eb);
        exp_t e;
        @(negedge clk);
        a1 = ta; b1 = tb_v; start1 = 1'b1;
        e.cyc = cyc + 2; e.d = {7'h0, ed}; e.bo = eb; e.ov = 1'b0;
        q1.push_back(e);
        @(negedge clk);
        start1 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (q.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        chk("scoreboard_drained", q.size() + q1.size(), 0);
    endtask

    initial begin
        int c0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_done", {31'h0, done}, 0);
        chk("rst_diff", {24'h0, diff}, 0);
        chk("rst_borrow", {31'h0, borrow_out}, 0);
        chk("rst_ovf", {31'h0, ovf}, 0);
        chk("rst_busy_w1", {31'h0, busy1}, 0);
        rst = 1'b0;

        run_op(8'h5A, 8'h21, 8'h39, 1'b0, 1'b0);
        run_op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
        run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

        // Abort in the 4th RUN cycle: no done, outputs back to reset values.
        @(negedge clk);
        a = 8'h33; b = 8'h11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'h0, busy}, 0);
        chk("abort_done", {31'h0, done}, 0);
        chk("abort_diff", {24'h0, diff}, 0);
        chk("abort_borrow", {31'h0, borrow_out}, 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        run_op(8'h33, 8'h11, 8'h22, 1'b0, 1'b0);

        // Start held high: one accepted op every WIDTH+2 cycles.
        @(negedge clk);
        a = 8'h05; b = 8'h03; start = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e.cyc = c0 + 9 + 10 * k; e.d = 8'h02; e.bo = 1'b0; e.ov = 1'b0;
            q.push_back(e);
        end
        repeat (30) @(negedge clk);
        start = 1'b0;
        drain();

        run1(1'b0, 1'b1, 1'b1, 1'b1);
        run1(1'b1, 1'b0, 1'b1, 1'b0);
        run1(1'b1, 1'b1, 1'b0, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
